// File: rtl/icache_refill_unit.sv
// icache_refill_unit
//   Instruction-cache miss service engine. Accepts one miss at a time, issues a
//   single burst read for the whole line, gathers WORDS_PER_LINE beats into a
//   line buffer, then writes line/index/tag into cache storage with a one-cycle
//   strobe. A beat error anywhere in the burst turns the write into an error
//   completion so the cache is never written with bad data.
//
//   Optional feature macro: ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
//     When defined, the burst starts at the missing word (memory wraps), beats
//     are placed from that word onward, and crit_valid/crit_data present the
//     first beat early.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   miss_valid/ready    miss request handshake (ready = unit idle)
//   miss_addr           byte address of the missing instruction
//   mem_req_valid/ready burst read request handshake
//   mem_req_addr        burst start address
//   mem_rsp_valid       response beat strobe (no backpressure)
//   mem_rsp_data/err    beat data and error flag
//   fill_we             one-cycle line write strobe
//   fill_index/tag/line line write payload
//   fill_done           one-cycle successful completion pulse
//   fill_err            one-cycle error completion pulse
//   crit_valid/data     (macro only) first-beat early restart
//
// States
//   IDLE  | waiting for a miss, miss_ready high
//   REQ   | burst request held until memory accepts
//   RECV  | collecting response beats
//   WRITE | line written to cache storage this cycle
//   ERR   | burst finished with an error, no write

module icache_refill_unit #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int NUM_LINES      = 32,
    localparam int OFF_W         = $clog2(WORDS_PER_LINE),
    localparam int IDX_W         = $clog2(NUM_LINES),
    localparam int TAG_W         = ADDR_W - IDX_W - OFF_W - 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             miss_valid,
    output logic                             miss_ready,
    input  logic [ADDR_W-1:0]                miss_addr,
    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic [ADDR_W-1:0]                mem_req_addr,
    input  logic                             mem_rsp_valid,
    input  logic [DATA_W-1:0]                mem_rsp_data,
    input  logic                             mem_rsp_err,
    output logic                             fill_we,
    output logic [IDX_W-1:0]                 fill_index,
    output logic [TAG_W-1:0]                 fill_tag,
    output logic [WORDS_PER_LINE*DATA_W-1:0] fill_line,
    output logic                             fill_done,
    output logic                             fill_err
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    ,
    output logic                             crit_valid,
    output logic [DATA_W-1:0]                crit_data
`endif
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] RECV  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] ERR   = 3'd4;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);
`else
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(WORDS_PER_LINE*4 - 1);
`endif

    logic [2:0]                       state;
    logic [ADDR_W-1:0]                addr_q;
    logic [OFF_W-1:0]                 beat_cnt;
    logic [OFF_W-1:0]                 start_word;
    logic [OFF_W-1:0]                 slot;
    logic                             err_q;
    logic                             write_q;
    logic                             err_pulse_q;
    logic [WORDS_PER_LINE*DATA_W-1:0] line_buf;
    logic                             last_beat;

    assign miss_ready = (state == IDLE);
    assign last_beat  = (beat_cnt == OFF_W'(WORDS_PER_LINE - 1));
    // OFF_W-bit add wraps the slot around the line
    assign slot       = start_word + beat_cnt;

    // addr_q already holds the burst start address, so the request and the
    // fill payload are plain slices of one register
    assign mem_req_addr = addr_q;
    assign fill_index   = addr_q[OFF_W+2 +: IDX_W];
    assign fill_tag     = addr_q[ADDR_W-1 -: TAG_W];
    assign fill_line    = line_buf;
    assign fill_we      = write_q;
    assign fill_done    = write_q;
    assign fill_err     = err_pulse_q;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_word <= '0;
            crit_valid <= 1'b0;
            crit_data  <= '0;
        end else begin
            crit_valid <= 1'b0;
            if (state == IDLE && miss_valid) begin
                start_word <= miss_addr[OFF_W+1:2];
            end
            if (state == RECV && mem_rsp_valid && beat_cnt == '0 && !mem_rsp_err) begin
                crit_valid <= 1'b1;
                crit_data  <= mem_rsp_data;
            end
        end
    end
`else
    assign start_word = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            addr_q        <= '0;
            beat_cnt      <= '0;
            err_q         <= 1'b0;
            write_q       <= 1'b0;
            err_pulse_q   <= 1'b0;
            mem_req_valid <= 1'b0;
            line_buf      <= '0;
        end else begin
            write_q     <= 1'b0;
            err_pulse_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss_valid) begin
                        addr_q        <= miss_addr & ADDR_MASK;
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        beat_cnt      <= '0;
                        err_q         <= 1'b0;
                        state         <= RECV;
                    end
                end
                RECV: begin
                    if (mem_rsp_valid) begin
                        line_buf[slot*DATA_W +: DATA_W] <= mem_rsp_data;
                        beat_cnt <= beat_cnt + OFF_W'(1);
                        if (mem_rsp_err) begin
                            err_q <= 1'b1;
                        end
                        if (last_beat) begin
                            if (err_q || mem_rsp_err) begin
                                err_pulse_q <= 1'b1;
                                state       <= ERR;
                            end else begin
                                write_q <= 1'b1;
                                state   <= WRITE;
                            end
                        end
                    end
                end
                WRITE:   state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_unit.sv
module tb_icache_refill_unit;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         miss_valid = 1'b0;
    logic         miss_ready;
    logic [31:0]  miss_addr = '0;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic [31:0]  mem_req_addr;
    logic         mem_rsp_valid = 1'b0;
    logic [31:0]  mem_rsp_data = '0;
    logic         mem_rsp_err = 1'b0;
    logic         fill_we;
    logic [4:0]   fill_index;
    logic [22:0]  fill_tag;
    logic [127:0] fill_line;
    logic         fill_done;
    logic         fill_err;
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    logic         crit_valid;
    logic [31:0]  crit_data;
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    int total  = 0;
    int passed = 0;

    icache_refill_unit dut (
        .clk(clk), .reset(reset),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .fill_we(fill_we), .fill_index(fill_index), .fill_tag(fill_tag), .fill_line(fill_line),
        .fill_done(fill_done), .fill_err(fill_err)
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
        , .crit_valid(crit_valid), .crit_data(crit_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_req_addr(input logic [31:0] a);
        return CWF ? (a & ~32'h3) : (a & ~32'hF);
    endfunction

    // beat i sits at beats[i*32 +: 32]; it lands in word (start + i) mod 4
    function automatic logic [127:0] place(input logic [127:0] beats, input logic [31:0] a);
        logic [127:0] line;
        int start;
        start = CWF ? int'(a[3:2]) : 0;
        line = '0;
        for (int i = 0; i < 4; i++) line[((start + i) % 4)*32 +: 32] = beats[i*32 +: 32];
        return line;
    endfunction

    task automatic test_reset;
        #2;
        total++; if (miss_ready !== 1'b1) $display("FAIL reset_miss_ready got %0b want 1", miss_ready); else passed++;
        total++; if (mem_req_valid !== 1'b0) $display("FAIL reset_req_valid got %0b want 0", mem_req_valid); else passed++;
        total++; if ({fill_we, fill_done, fill_err} !== 3'b000) $display("FAIL reset_pulses got %b want 000", {fill_we, fill_done, fill_err}); else passed++;
        total++; if (mem_req_addr !== 32'h0) $display("FAIL reset_req_addr got %h want 0", mem_req_addr); else passed++;
        total++; if ({fill_index, fill_tag} !== 28'h0) $display("FAIL reset_idx_tag got %h want 0", {fill_index, fill_tag}); else passed++;
        total++; if (fill_line !== 128'h0) $display("FAIL reset_line got %h want 0", fill_line); else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_fill;
        logic [127:0] beats;
        int early;
        beats = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        early = 0;
        tick;                                   // cycle 0
        miss_valid = 1'b1; miss_addr = 32'h0000_0104;
        total++; if (miss_ready !== 1'b1) $display("FAIL basic_ready0 got %0b want 1", miss_ready); else passed++;
        tick;                                   // cycle 1
        miss_valid = 1'b0; mem_req_ready = 1'b1;
        total++; if (mem_req_valid !== 1'b1) $display("FAIL basic_req_valid got %0b want 1", mem_req_valid); else passed++;
        total++; if (mem_req_addr !== exp_req_addr(32'h104)) $display("FAIL basic_req_addr got %h want %h", mem_req_addr, exp_req_addr(32'h104)); else passed++;
        tick;                                   // cycle 2
        mem_req_ready = 1'b0;
        total++; if (mem_req_valid !== 1'b0) $display("FAIL basic_req_drop got %0b want 0", mem_req_valid); else passed++;
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = beats[i*32 +: 32];
            if (fill_we) early++;
            tick;
        end
        mem_rsp_valid = 1'b0;                   // cycle 6
        total++; if (early !== 0) $display("FAIL basic_early_we got %0d want 0", early); else passed++;
        total++; if ({fill_we, fill_done} !== 2'b11) $display("FAIL basic_we_done got %b want 11", {fill_we, fill_done}); else passed++;
        total++; if (fill_index !== 5'd16) $display("FAIL basic_index got %0d want 16", fill_index); else passed++;
        total++; if (fill_tag !== 23'd0) $display("FAIL basic_tag got %h want 0", fill_tag); else passed++;
        total++; if (fill_line !== place(beats, 32'h104)) $display("FAIL basic_line got %h want %h", fill_line, place(beats, 32'h104)); else passed++;
        tick;                                   // cycle 7
        total++; if ({fill_we, miss_ready} !== 2'b01) $display("FAIL basic_after got we/ready %b want 01", {fill_we, miss_ready}); else passed++;
    endtask

    task automatic test_backpressure;
        logic [127:0] beats;
        int bad_req, early;
        beats = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        bad_req = 0; early = 0;
        tick;
        miss_valid = 1'b1; miss_addr = 32'h0000_1238;
        tick;
        miss_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // stray beat while the request is pending must be ignored
            mem_rsp_valid = (i == 1); mem_rsp_data = 32'hDEAD_BEEF;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_req_addr(32'h1238)) bad_req++;
            tick;
        end
        mem_rsp_valid = 1'b0;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_req_addr(32'h1238)) bad_req++;
        mem_req_ready = 1'b1;
        total++; if (bad_req !== 0) $display("FAIL bp_req_stable got %0d bad cycles want 0", bad_req); else passed++;
        tick;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = beats[i*32 +: 32];
            if (fill_we) early++;
            tick;
            if (i < 3) begin
                mem_rsp_valid = 1'b0;
                if (fill_we) early++;
                tick;
            end
        end
        mem_rsp_valid = 1'b0;
        total++; if (early !== 0) $display("FAIL bp_early_we got %0d want 0", early); else passed++;
        total++; if (fill_we !== 1'b1) $display("FAIL bp_we got %0b want 1", fill_we); else passed++;
        total++; if ({fill_index, fill_tag} !== {5'd3, 23'd9}) $display("FAIL bp_idx_tag got %0d/%0d want 3/9", fill_index, fill_tag); else passed++;
        total++; if (fill_line !== place(beats, 32'h1238)) $display("FAIL bp_line got %h want %h", fill_line, place(beats, 32'h1238)); else passed++;
        tick;
    endtask

    task automatic test_error_beat;
        int we_seen, err_seen;
        we_seen = 0; err_seen = 0;
        tick;
        miss_valid = 1'b1; miss_addr = 32'h0000_0200;
        tick;
        miss_valid = 1'b0; mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = 32'hE0 + i; mem_rsp_err = (i == 1);
            if (fill_err) err_seen++;
            if (fill_we || fill_done) we_seen++;
            tick;
        end
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        total++; if (err_seen !== 0) $display("FAIL err_early got %0d pulses want 0", err_seen); else passed++;
        total++; if (fill_err !== 1'b1) $display("FAIL err_pulse got %0b want 1", fill_err); else passed++;
        if (fill_we || fill_done) we_seen++;
        tick;
        if (fill_we || fill_done) we_seen++;
        total++; if (we_seen !== 0) $display("FAIL err_no_write got %0d want 0", we_seen); else passed++;
        total++; if ({fill_err, miss_ready} !== 2'b01) $display("FAIL err_after got err/ready %b want 01", {fill_err, miss_ready}); else passed++;
    endtask

    task automatic test_after_error;
        logic [127:0] beats;
        beats = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        tick;
        miss_valid = 1'b1; miss_addr = 32'h0000_0A40;
        tick;
        miss_valid = 1'b0; mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = beats[i*32 +: 32];
            tick;
        end
        mem_rsp_valid = 1'b0;
        total++; if ({fill_we, fill_err} !== 2'b10) $display("FAIL clean_we_err got %b want 10", {fill_we, fill_err}); else passed++;
        total++; if ({fill_index, fill_tag} !== {5'd4, 23'd5}) $display("FAIL clean_idx_tag got %0d/%0d want 4/5", fill_index, fill_tag); else passed++;
        total++; if (fill_line !== place(beats, 32'hA40)) $display("FAIL clean_line got %h want %h", fill_line, place(beats, 32'hA40)); else passed++;
        tick;
    endtask

    task automatic test_reset_mid_fill;
        int we_seen;
        we_seen = 0;
        tick;
        miss_valid = 1'b1; miss_addr = 32'h0000_0300;
        tick;
        miss_valid = 1'b0; mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5500 + i;
            tick;
        end
        mem_rsp_valid = 1'b0;
        reset = 1'b1;
        #1;
        total++; if ({miss_ready, mem_req_valid} !== 2'b10) $display("FAIL rst_mid_state got ready/req %b want 10", {miss_ready, mem_req_valid}); else passed++;
        total++; if (fill_line !== 128'h0) $display("FAIL rst_mid_line got %h want 0", fill_line); else passed++;
        total++; if ({mem_req_addr, fill_index, fill_tag} !== 60'h0) $display("FAIL rst_mid_addr got %h/%0d/%0d want 0", mem_req_addr, fill_index, fill_tag); else passed++;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (fill_we || fill_done) we_seen++;
            tick;
        end
        total++; if (we_seen !== 0) $display("FAIL rst_mid_no_write got %0d want 0", we_seen); else passed++;
        total++; if (miss_ready !== 1'b1) $display("FAIL rst_mid_ready got %0b want 1", miss_ready); else passed++;
    endtask

    task automatic test_miss_while_busy;
        logic [127:0] beats;
        int busy_bad;
        beats = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
        busy_bad = 0;
        tick;                                   // cycle 0
        miss_valid = 1'b1; miss_addr = 32'h0000_0400;
        tick;                                   // cycle 1
        miss_addr = 32'h0000_1FF0; mem_req_ready = 1'b1;
        if (miss_ready !== 1'b0) busy_bad++;
        tick;                                   // cycle 2
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = 32'h4000 + i;
            if (miss_ready !== 1'b0) busy_bad++;
            tick;
        end
        mem_rsp_valid = 1'b0;                   // cycle 6
        if (miss_ready !== 1'b0) busy_bad++;
        total++; if (busy_bad !== 0) $display("FAIL busy_ready got %0d cycles ready want 0", busy_bad); else passed++;
        total++; if ({fill_we, fill_index, fill_tag} !== {1'b1, 5'd0, 23'd2}) $display("FAIL busy_first got we=%0b idx=%0d tag=%0d want 1/0/2", fill_we, fill_index, fill_tag); else passed++;
        tick;                                   // cycle 7: second miss accepted here
        total++; if (miss_ready !== 1'b1) $display("FAIL busy_ready_back got %0b want 1", miss_ready); else passed++;
        tick;                                   // cycle 8
        miss_valid = 1'b0; mem_req_ready = 1'b1;
        total++; if ({mem_req_valid, mem_req_addr} !== {1'b1, exp_req_addr(32'h1FF0)}) $display("FAIL busy_second_req got %0b/%h want 1/%h", mem_req_valid, mem_req_addr, exp_req_addr(32'h1FF0)); else passed++;
        tick;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = beats[i*32 +: 32];
            tick;
        end
        mem_rsp_valid = 1'b0;
        total++; if ({fill_we, fill_index, fill_tag} !== {1'b1, 5'd31, 23'd15}) $display("FAIL busy_second got we=%0b idx=%0d tag=%0d want 1/31/15", fill_we, fill_index, fill_tag); else passed++;
        total++; if (fill_line !== place(beats, 32'h1FF0)) $display("FAIL busy_second_line got %h want %h", fill_line, place(beats, 32'h1FF0)); else passed++;
        tick;
    endtask

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    task automatic test_cwf;
        logic [127:0] beats;
        beats = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        tick;
        miss_valid = 1'b1; miss_addr = 32'h0000_010C;
        tick;
        miss_valid = 1'b0; mem_req_ready = 1'b1;
        total++; if (mem_req_addr !== 32'h10C) $display("FAIL cwf_req_addr got %h want 10c", mem_req_addr); else passed++;
        tick;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = beats[i*32 +: 32];
            tick;
            if (i == 0) begin
                total++; if ({crit_valid, crit_data} !== {1'b1, 32'hD0}) $display("FAIL cwf_crit got %0b/%h want 1/d0", crit_valid, crit_data); else passed++;
            end
            if (i == 1) begin
                total++; if (crit_valid !== 1'b0) $display("FAIL cwf_crit_once got %0b want 0", crit_valid); else passed++;
            end
        end
        mem_rsp_valid = 1'b0;
        total++; if (fill_line !== {32'hD0, 32'hD3, 32'hD2, 32'hD1}) $display("FAIL cwf_line got %h want d0/d3/d2/d1", fill_line); else passed++;
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_basic_fill;
        test_backpressure;
        test_error_beat;
        test_after_error;
        test_reset_mid_fill;
        test_miss_while_busy;
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
        test_cwf;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
